// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule slice.
//   AES_NR      : number of expansion rounds for AES-128
//   KEY_W       : cipher / round-key width
//   WORD_W      : key-schedule word width
//   ks_state_e  : key-schedule controller state
//   rk_store_t  : 11 x 128 round-key store (entry r = round key r)
package aes_pkg;
    localparam int AES_NR = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    typedef enum logic {
        ST_IDLE,
        ST_EXPAND
    } ks_state_e;

    typedef logic [AES_NR:0][KEY_W-1:0] rk_store_t;
endpackage

// File: rtl/g_func.sv
// AES-128 key-schedule g transform: RotWord, SubWord, then Rcon on the top byte.
//   w     : last word of the previous round key
//   round : round index 1..10 selecting Rcon
//   g     : transformed word
module g_func
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] w,
    input  logic [3:0]        round,
    output logic [WORD_W-1:0] g
);
    logic [WORD_W-1:0] rot, sub;
    logic [7:0]        rcon;

    assign rot = {w[23:0], w[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sb
        sbox u_sbox (.a(rot[8*i +: 8]), .s(sub[8*i +: 8]));
    end

    always_comb begin
        case (round)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
        g = sub ^ {rcon, 24'h000000};
    end
endmodule

// File: rtl/sbox.sv
// AES forward S-box, computed as GF(2^8) inverse followed by the affine map.
//   a : input byte
//   s : substituted byte
module sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p, xx, yy;
        p  = 8'h00;
        xx = x;
        yy = y;
        for (int i = 0; i < 8; i++) begin
            if (yy[0]) p = p ^ xx;
            xx = xx[7] ? ((xx << 1) ^ 8'h1b) : (xx << 1);
            yy = yy >> 1;
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse (and maps 0 to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] r, sq;
        r  = 8'h01;
        sq = x;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] b;

    always_comb begin
        b = gf_inv(a);
        s = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
              ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-schedule controller and round-key store.
// One round key per clock; keys are streamed out and kept in an 11-entry store
// read back by the cipher datapath.
//   clk, rst_n   : clock, async active-low reset
//   start,key_in : expansion request and cipher key (accepted when !busy)
//   busy         : expansion in progress
//   rk_valid     : round_key / rk_round valid
//   rk_round     : index of streamed key (0..10)
//   round_key    : streamed round key
//   done         : pulse with round 10
//   keys_ready   : store holds a complete schedule
//   rd_addr      : store read index; rd_data registered, 0 for index > 10
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int NR = AES_NR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             rk_valid,
    output logic [3:0]       rk_round,
    output logic [KEY_W-1:0] round_key,
    output logic             done,
    output logic             keys_ready,
    input  logic [3:0]       rd_addr,
    output logic [KEY_W-1:0] rd_data
);
    ks_state_e         state;
    rk_store_t         store;
    logic [3:0]        nxt_idx;
    logic [WORD_W-1:0] g, w4, w5, w6, w7;

    // round_key doubles as the working register; the next key is built from it.
    assign nxt_idx = rk_round + 4'd1;

    g_func u_g (.w(round_key[31:0]), .round(nxt_idx), .g(g));

    always_comb begin
        w4 = round_key[127:96] ^ g;
        w5 = round_key[95:64]  ^ w4;
        w6 = round_key[63:32]  ^ w5;
        w7 = round_key[31:0]   ^ w6;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            rk_valid   <= 1'b0;
            rk_round   <= 4'd0;
            round_key  <= '0;
            done       <= 1'b0;
            keys_ready <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_EXPAND;
                        busy       <= 1'b1;
                        rk_valid   <= 1'b1;
                        rk_round   <= 4'd0;
                        round_key  <= key_in;
                        done       <= 1'b0;
                        keys_ready <= 1'b0;
                    end
                end
                ST_EXPAND: begin
                    // start is deliberately ignored here, including the done cycle.
                    if (rk_round == 4'(NR)) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        rk_valid   <= 1'b0;
                        done       <= 1'b0;
                        keys_ready <= 1'b1;
                    end else begin
                        round_key <= {w4, w5, w6, w7};
                        rk_round  <= nxt_idx;
                        done      <= (nxt_idx == 4'(NR));
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Store write lands at the end of the rk_valid cycle; reads see old data
    // until then (no forwarding).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store   <= '0;
            rd_data <= '0;
        end else begin
            if (rk_valid) store[rk_round] <= round_key;
            rd_data <= (rd_addr <= 4'(AES_NR)) ? store[rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;
    logic         clk, rst_n, start;
    logic [127:0] key_in;
    logic         busy, rk_valid, done, keys_ready;
    logic [3:0]   rk_round, rd_addr;
    logic [127:0] round_key, rd_data;

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] key;
    } vec_t;

    vec_t fips[11];
    vec_t rdv[6];

    localparam logic [127:0] KEY_A = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_Z = 128'h0;

    aes_key_sched_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .key_in(key_in),
        .busy(busy), .rk_valid(rk_valid), .rk_round(rk_round),
        .round_key(round_key), .done(done), .keys_ready(keys_ready),
        .rd_addr(rd_addr), .rd_data(rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic stream_chk(input int k, input logic [127:0] exp_key);
        chk($sformatf("busy r%0d", k), 128'(busy), 128'(1));
        chk($sformatf("rk_valid r%0d", k), 128'(rk_valid), 128'(1));
        chk($sformatf("rk_round r%0d", k), 128'(rk_round), 128'(k));
        chk($sformatf("done r%0d", k), 128'(done), 128'(k == 10));
        chk($sformatf("round_key r%0d", k), round_key, exp_key);
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, " busy"}, 128'(busy), 128'(0));
        chk({tag, " rk_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, " done"}, 128'(done), 128'(0));
        chk({tag, " keys_ready"}, 128'(keys_ready), 128'(1));
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, " busy"}, 128'(busy), 128'(0));
        chk({tag, " rk_valid"}, 128'(rk_valid), 128'(0));
        chk({tag, " done"}, 128'(done), 128'(0));
        chk({tag, " keys_ready"}, 128'(keys_ready), 128'(0));
        chk({tag, " rk_round"}, 128'(rk_round), 128'(0));
        chk({tag, " round_key"}, round_key, 128'(0));
        chk({tag, " rd_data"}, rd_data, 128'(0));
    endtask

    task automatic rd_chk(input logic [3:0] a, input logic [127:0] exp);
        rd_addr = a;
        tick();
        chk($sformatf("rd_data[%0d]", a), rd_data, exp);
    endtask

    initial begin
        fips[0]  = '{4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
        fips[1]  = '{4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
        fips[2]  = '{4'd2,  128'hf2c295f27a96b9435935807a7359f67f};
        fips[3]  = '{4'd3,  128'h3d80477d4716fe3e1e237e446d7a883b};
        fips[4]  = '{4'd4,  128'hef44a541a8525b7fb671253bdb0bad00};
        fips[5]  = '{4'd5,  128'hd4d1c6f87c839d87caf2b8bc11f915bc};
        fips[6]  = '{4'd6,  128'h6d88a37a110b3efddbf98641ca0093fd};
        fips[7]  = '{4'd7,  128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
        fips[8]  = '{4'd8,  128'head27321b58dbad2312bf5607f8d292f};
        fips[9]  = '{4'd9,  128'hac7766f319fadc2128d12941575c006e};
        fips[10] = '{4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        rdv[0] = '{4'd0,  fips[0].key};
        rdv[1] = '{4'd10, fips[10].key};
        rdv[2] = '{4'd15, 128'h0};
        rdv[3] = '{4'd5,  fips[5].key};
        rdv[4] = '{4'd11, 128'h0};
        rdv[5] = '{4'd1,  fips[1].key};

        rst_n = 1'b0; start = 1'b0; key_in = '0; rd_addr = 4'd0;
        #12;
        zero_chk("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Plain FIPS-197 expansion, every round checked.
        start = 1'b1; key_in = KEY_A;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            stream_chk(k, fips[k].key);
            if (k < 10) tick();
        end
        tick();
        idle_chk("after A");

        for (int i = 0; i < 6; i++) rd_chk(rdv[i].idx, rdv[i].key);

        // Starts with another key at round 5 and in the done cycle are ignored.
        start = 1'b1; key_in = KEY_A;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            stream_chk(k, fips[k].key);
            if (k == 5 || k == 10) begin start = 1'b1; key_in = KEY_Z; end
            tick();
            start = 1'b0;
        end
        idle_chk("ignored starts");

        // Back-to-back: zero key accepted at the first legal edge.
        start = 1'b1; key_in = KEY_Z;
        tick();
        start = 1'b0;
        chk("b2b keys_ready drop", 128'(keys_ready), 128'(0));
        stream_chk(0, KEY_Z);
        tick();
        stream_chk(1, 128'h62636363626363636263636362636363);
        repeat (9) tick();
        stream_chk(10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        tick();
        idle_chk("after B");
        rd_chk(4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        // Async reset in the middle of round 7, between clock edges.
        start = 1'b1; key_in = KEY_A;
        tick();
        start = 1'b0;
        repeat (7) tick();
        stream_chk(7, fips[7].key);
        #2 rst_n = 1'b0;
        #1 zero_chk("async reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("no done after reset", 128'(done), 128'(0));
        end
        rd_chk(4'd10, 128'h0);

        // Fresh schedule after reset.
        start = 1'b1; key_in = KEY_A;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            stream_chk(k, fips[k].key);
            if (k < 10) tick();
        end
        tick();
        idle_chk("after reset run");
        rd_chk(4'd10, fips[10].key);
        rd_chk(4'd3, fips[3].key);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/aes_key_sched_ctrl.md
# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller. On a start request it loads a 128-bit cipher key, then steps the existing `g_func` word-transform one round per clock to produce round keys 0–10. Each key is streamed out with a valid strobe and also written into an internal 11-entry round-key store. The cipher datapath reads that store by round index, which makes this block the single sequencer and owner of `g_func` in the AES core.

## Interface
Parameters:
- `NR`, default 10: number of expansion rounds. Fixed at 10 for AES-128; other values are unsupported.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new key expansion. Sampled on rising `clk`.
- `key_in`  in  128  cipher key, captured in the start-accept cycle. `key_in[127:96]` is w0.
- `busy`  out  1  expansion in progress.
- `rk_valid`  out  1  `round_key` and `rk_round` are valid this cycle.
- `rk_round`  out  4  index (0–10) of the key on `round_key`.
- `round_key`  out  128  streamed round key.
- `done`  out  1  one-cycle pulse, coincident with round 10.
- `keys_ready`  out  1  level: the store holds a complete schedule.
- `rd_addr`  in  4  store read index.
- `rd_data`  out  128  store read data, registered.

## Operation
- States:
  - IDLE: the reset state.
  - EXPAND: runs for 11 cycles, generating rounds 0–10.
  - IDLE: re-entered after round 10.
- Start acceptance: `start` is accepted only when `busy`=0. An accepted start clears `keys_ready`, loads `key_in` into the working register, and sets the round counter to 0.
- Start while `busy`=1 is ignored and does not abort the current expansion. This includes a start in the round-10/`done` cycle.
- Round 0: `round_key` = captured `key_in`.
- Round r (1–10):
  - `g_func` is driven with w3 of the previous key and `round`=r.
  - w4 = w0 ^ g
  - w5 = w1 ^ w4
  - w6 = w2 ^ w5
  - w7 = w3 ^ w6
  - New key = {w4, w5, w6, w7}.
- Store: each key is written to entry `rk_round` in the cycle `rk_valid`=1. `keys_ready` rises in the cycle after `done`.
- Read port: `rd_data` equals entry `rd_addr`, registered with 1-cycle latency.
  - `rd_addr` > 10 returns 0.
  - Reads are legal at any time. Reading an entry during expansion returns its old value until that entry is rewritten; the read port performs no write-forwarding.
- Arithmetic: pure XOR, so there is no width growth. The round counter is 4 bits and never exceeds 10.

## Timing
- Start accepted at edge T:
  - `busy`=1 and `rk_valid`=1 on cycles T+1 through T+11.
  - `rk_round` is 0 at T+1 and 10 at T+11.
  - `done`=1 at T+11 only.
  - `busy`=0 and `keys_ready`=1 from T+12.
- Throughput: one round key per clock. A new start is accepted at the earliest at edge T+12, which gives 11-cycle back-to-back expansions.
- Reset values, all with asynchronous clear:
  - `busy`, `rk_valid`, `done`, `keys_ready` = 0.
  - `rk_round` = 0, `round_key` = 0, `rd_data` = 0.
  - All store entries = 0.
- Reset mid-expansion: all outputs take their reset values immediately, without waiting for a clock edge. The partial schedule is discarded and no `done` is issued.
- The combinational path is working-register → `g_func` (S-box) → XOR chain → register. It must close within one `clk` period.

## Structure
- Shared package `aes_pkg` holds:
  - `AES_NR` = 10, `KEY_W` = 128, `WORD_W` = 32.
  - The state enum type.
  - The round-key array typedef, 11 × 128.
- Sub-module: one instance of the existing `g_func`, which in turn instantiates `sbox`.
- Expansion control and the 11 × 128 store stay in this module; there are no further sub-modules.

## Test plan
- FIPS-197 key: `key_in`=2b7e151628aed2a6abf7158809cf4f3c, pulse `start`.
  - Rounds stream on T+1..T+11 as specified in Timing.
  - Round 1 = a0fafe1788542cb123a339392a6c7605.
  - Round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done`=1 in the same cycle.
- Store readback after `keys_ready`: reading `rd_addr`=0 gives `rd_data`=2b7e…4f3c one cycle later; `rd_addr`=10 gives d014…0ca6; `rd_addr`=15 gives 0.
- Start during expansion: assert `start` with a different key at `rk_round`=5 and again in the `done` cycle.
  - Sequence is unchanged and the results match the first key.
  - The next start is accepted only at T+12.
- Back-to-back: start key A, then start key B at the first legal edge.
  - `keys_ready` drops at B's accept edge.
  - B's round 10 is correct; key 00…00 gives round 10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- Async reset: deassert `rst_n` between clock edges at `rk_round`=7.
  - All outputs go to 0 immediately, with no `done` issued.
  - After release, a fresh start produces a correct schedule.
